mpu_ctrl_fsm: RTL and testbench

- Central control FSM of the matrix processing unit.
- Decodes an 8-bit host instruction and sequences the four BRAMs (B0..B3), the ALU result mux and the host in/out paths.
- Handles byte-serial LOAD/UNLOAD with the host, whole-chunk COPY/CLEAR, and ALU ops (dst = dst op src). Asserts busy while an operation runs.

---
 rtl/mpu_pkg.sv | 69 ++++++
 rtl/mpu_instr_decode.sv | 51 +++++
 rtl/mpu_ctrl_fsm.sv | 132 +++++++++++++
 tb/tb_mpu_ctrl_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared types for the matrix processing unit control path.
// Holds the instruction field encodings, the FSM state enum, the decoded
// control bundle and a helper that classifies an instruction by the
// sequencing it needs (none / byte-serial / whole-chunk).
package mpu_pkg;

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} bram_id_e;

  typedef enum logic [1:0] {
    ADDER      = 2'b00,
    SHIFTER    = 2'b01,
    SUBTRACTOR = 2'b10,
    MULTIPLIER = 2'b11
  } alu_op_e;

  // cls=10 is unassigned and behaves as NOP.
  typedef enum logic [1:0] {
    CLS_NOP  = 2'b00,
    CLS_MOVE = 2'b01,
    CLS_RSVD = 2'b10,
    CLS_ALU  = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    MV_LOAD   = 2'b00,
    MV_COPY   = 2'b01,
    MV_UNLOAD = 2'b10,
    MV_CLEAR  = 2'b11
  } move_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BYTE_OP  = 2'd1,
    ST_CHUNK_OP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEQ_NONE  = 2'd0,
    SEQ_BYTE  = 2'd1,
    SEQ_CHUNK = 2'd2
  } seq_e;

  typedef struct packed {
    logic [1:0] aa_mux;
    logic [1:0] dd_mux;
    logic [1:0] bram_mux;
    logic [1:0] out_mux;
    logic [1:0] host_out_mux;
    logic       bram_in_mux;
    logic [3:0] b_en;
    logic [3:0] b_en1;
    logic [3:0] b_rst;
  } ctrl_t;

  function automatic seq_e instr_seq(input logic [7:0] instr);
    seq_e s;
    s = SEQ_NONE;
    case (instr[3:2])
      CLS_MOVE: begin
        if (instr[1:0] == MV_LOAD || instr[1:0] == MV_UNLOAD) s = SEQ_BYTE;
        else                                                 s = SEQ_CHUNK;
      end
      CLS_ALU: s = SEQ_CHUNK;
      default: s = SEQ_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mpu_instr_decode.sv
// Combinational decode of a latched 8-bit host instruction into the MPU
// control bundle. Fields not used by the decoded operation are 0.
// Ports:
//   i_instr : instruction {dst[7:6], src[5:4], cls[3:2], op[1:0]}
//   o_ctrl  : decoded mux selects and per-BRAM enable/clear vectors
module mpu_instr_decode
  import mpu_pkg::*;
(
  input  logic [7:0] i_instr,
  output ctrl_t      o_ctrl
);

  logic [1:0] w_dst;
  logic [1:0] w_src;
  logic [1:0] w_cls;
  logic [1:0] w_op;
  logic [3:0] w_dst_1h;

  assign w_dst    = i_instr[7:6];
  assign w_src    = i_instr[5:4];
  assign w_cls    = i_instr[3:2];
  assign w_op     = i_instr[1:0];
  assign w_dst_1h = 4'b0001 << w_dst;

  always_comb begin
    o_ctrl = '0;
    case (w_cls)
      CLS_MOVE: begin
        case (w_op)
          MV_LOAD:   o_ctrl.b_en1 = w_dst_1h;
          MV_UNLOAD: o_ctrl.host_out_mux = w_dst;
          MV_COPY: begin
            o_ctrl.bram_mux    = w_src;
            o_ctrl.bram_in_mux = 1'b1;
            o_ctrl.b_en        = w_dst_1h;
          end
          default:   o_ctrl.b_rst = w_dst_1h;
        endcase
      end
      CLS_ALU: begin
        o_ctrl.aa_mux      = w_src;
        o_ctrl.dd_mux      = w_dst;
        o_ctrl.out_mux     = w_op;
        o_ctrl.bram_in_mux = 1'b0;
        o_ctrl.b_en        = w_dst_1h;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mpu_ctrl_fsm.sv
// Central control FSM of the matrix processing unit.
// Latches the host instruction in IDLE and sequences either a byte-serial
// LOAD/UNLOAD (num_bits/8 cycles, offset stepping by 8) or a whole-chunk
// COPY/CLEAR/ALU op (CHUNK_CYCLES cycles). Outputs are Moore: decoded from
// the latched instruction and forced to 0 in IDLE.
// Ports:
//   clk, reset (sync, active-low), host_instruction[7:0]
//   offset        : bit offset of current byte during LOAD/UNLOAD
//   aa_MUX/dd_MUX : ALU operand A (src) / D (dst) select
//   bram_MUX      : COPY source;  out_MUX: ALU unit select
//   host_out_MUX  : BRAM routed to host on UNLOAD
//   bram_in_MUX   : BRAM write source (1 copy path, 0 ALU)
//   busy          : operation in progress
//   bN_rst/bN_en/bN_en1 : per-BRAM clear / chunk write / byte write
module mpu_ctrl_fsm
  import mpu_pkg::*;
#(
  parameter int unsigned num_bits     = 512,
  parameter int unsigned CHUNK_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  host_instruction,
  output logic [$clog2(num_bits)-1:0] offset,
  output logic [1:0]                  aa_MUX,
  output logic [1:0]                  dd_MUX,
  output logic [1:0]                  bram_MUX,
  output logic [1:0]                  out_MUX,
  output logic [1:0]                  host_out_MUX,
  output logic                        bram_in_MUX,
  output logic                        busy,
  output logic                        b0_rst,
  output logic                        b1_rst,
  output logic                        b2_rst,
  output logic                        b3_rst,
  output logic                        b0_en,
  output logic                        b1_en,
  output logic                        b2_en,
  output logic                        b3_en,
  output logic                        b0_en1,
  output logic                        b1_en1,
  output logic                        b2_en1,
  output logic                        b3_en1
);

  localparam int unsigned OFF_W = $clog2(num_bits);
  localparam int unsigned BC_W  = $clog2(num_bits / 8);
  localparam int unsigned CC_W  = (CHUNK_CYCLES > 1) ? $clog2(CHUNK_CYCLES) : 1;

  state_e          r_state, w_state_nxt;
  logic [BC_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [CC_W-1:0] r_chunk_cnt, w_chunk_cnt_nxt;
  logic [7:0]      r_instr;
  ctrl_t           w_ctrl;
  ctrl_t           w_out;
  logic            w_act;

  mpu_instr_decode u_decode (
    .i_instr (r_instr),
    .o_ctrl  (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_chunk_cnt <= '0;
      r_instr     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_chunk_cnt <= w_chunk_cnt_nxt;
      if (r_state == ST_IDLE) r_instr <= host_instruction;
    end
  end

  // The transition out of IDLE is chosen from the incoming instruction so
  // that the op's controls appear in the cycle right after the capture edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_chunk_cnt_nxt = r_chunk_cnt;
    case (r_state)
      ST_IDLE: begin
        w_byte_cnt_nxt  = '0;
        w_chunk_cnt_nxt = '0;
        case (instr_seq(host_instruction))
          SEQ_BYTE:  w_state_nxt = ST_BYTE_OP;
          SEQ_CHUNK: w_state_nxt = ST_CHUNK_OP;
          default:   w_state_nxt = ST_IDLE;
        endcase
      end
      ST_BYTE_OP: begin
        if (r_byte_cnt == '1) begin
          w_state_nxt    = ST_IDLE;
          w_byte_cnt_nxt = '0;
        end else begin
          w_byte_cnt_nxt = r_byte_cnt + 1'b1;
        end
      end
      ST_CHUNK_OP: begin
        if (r_chunk_cnt == CC_W'(CHUNK_CYCLES - 1)) begin
          w_state_nxt     = ST_IDLE;
          w_chunk_cnt_nxt = '0;
        end else begin
          w_chunk_cnt_nxt = r_chunk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_byte_cnt_nxt  = '0;
        w_chunk_cnt_nxt = '0;
      end
    endcase
  end

  assign w_act = (r_state != ST_IDLE);
  assign w_out = w_act ? w_ctrl : '0;

  assign busy         = w_act;
  assign offset       = (r_state == ST_BYTE_OP) ? OFF_W'({r_byte_cnt, 3'b000}) : '0;
  assign aa_MUX       = w_out.aa_mux;
  assign dd_MUX       = w_out.dd_mux;
  assign bram_MUX     = w_out.bram_mux;
  assign out_MUX      = w_out.out_mux;
  assign host_out_MUX = w_out.host_out_mux;
  assign bram_in_MUX  = w_out.bram_in_mux;
  assign {b3_rst, b2_rst, b1_rst, b0_rst} = w_out.b_rst;
  assign {b3_en,  b2_en,  b1_en,  b0_en}  = w_out.b_en;
  assign {b3_en1, b2_en1, b1_en1, b0_en1} = w_out.b_en1;

endmodule

// File: tb/tb_mpu_ctrl_fsm.sv
module tb_mpu_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [7:0] host_instruction;
  logic [8:0] offset;
  logic [1:0] aa_MUX, dd_MUX, bram_MUX, out_MUX, host_out_MUX;
  logic       bram_in_MUX, busy;
  logic       b0_rst, b1_rst, b2_rst, b3_rst;
  logic       b0_en, b1_en, b2_en, b3_en;
  logic       b0_en1, b1_en1, b2_en1, b3_en1;

  int n_vec;
  int n_err;

  mpu_ctrl_fsm #(.num_bits(512), .CHUNK_CYCLES(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .host_instruction (host_instruction),
    .offset           (offset),
    .aa_MUX           (aa_MUX),
    .dd_MUX           (dd_MUX),
    .bram_MUX         (bram_MUX),
    .out_MUX          (out_MUX),
    .host_out_MUX     (host_out_MUX),
    .bram_in_MUX      (bram_in_MUX),
    .busy             (busy),
    .b0_rst           (b0_rst),
    .b1_rst           (b1_rst),
    .b2_rst           (b2_rst),
    .b3_rst           (b3_rst),
    .b0_en            (b0_en),
    .b1_en            (b1_en),
    .b2_en            (b2_en),
    .b3_en            (b3_en),
    .b0_en1           (b0_en1),
    .b1_en1           (b1_en1),
    .b2_en1           (b2_en1),
    .b3_en1           (b3_en1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every output:
  // {busy, offset[8:0], aa, dd, bram, out, host_out, bram_in, en[3:0], en1[3:0], rst[3:0]}
  function automatic logic [32:0] mk(input logic b, input logic [8:0] off,
                                     input logic [1:0] aa, input logic [1:0] dd,
                                     input logic [1:0] bm, input logic [1:0] om,
                                     input logic [1:0] hm, input logic bin,
                                     input logic [3:0] en, input logic [3:0] en1,
                                     input logic [3:0] rst);
    return {b, off, aa, dd, bm, om, hm, bin, en, en1, rst};
  endfunction

  function automatic logic [32:0] observed();
    return {busy, offset, aa_MUX, dd_MUX, bram_MUX, out_MUX, host_out_MUX, bram_in_MUX,
            {b3_en, b2_en, b1_en, b0_en}, {b3_en1, b2_en1, b1_en1, b0_en1},
            {b3_rst, b2_rst, b1_rst, b0_rst}};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [32:0] exp);
    logic [32:0] obs;
    obs = observed();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Byte op: capture edge, then 64 checked cycles, then back in IDLE.
  task automatic run_byte(input string tag, input logic [7:0] instr,
                          input bit is_load, input logic [1:0] d);
    host_instruction = instr;
    tick();
    host_instruction = 8'hC7;  // ignored while busy
    for (int i = 0; i < 64; i++) begin
      if (is_load) chk(tag, i, mk(1'b1, 9'(i * 8), 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0,
                                  4'd0, 4'b0001 << d, 4'd0));
      else         chk(tag, i, mk(1'b1, 9'(i * 8), 2'd0, 2'd0, 2'd0, 2'd0, d, 1'b0,
                                  4'd0, 4'd0, 4'd0));
      if (i == 60) host_instruction = 8'h00;
      tick();
    end
    chk({tag, "_end"}, 64, '0);
  endtask

  task automatic run_chunk(input string tag, input logic [7:0] instr,
                           input logic [32:0] exp);
    host_instruction = instr;
    tick();
    host_instruction = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk(tag, i, exp);
      tick();
    end
    chk({tag, "_end"}, 3, '0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    host_instruction = 8'h00;
    @(negedge clk);
    tick();
    chk("reset", 0, '0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nop_idle", i, '0);
    end
    host_instruction = 8'h88;  // cls=10 behaves as NOP
    tick();
    chk("cls10_nop", 0, '0);
    host_instruction = 8'h00;
    tick();

    run_byte("load_b0", 8'h04, 1'b1, 2'd0);
    run_byte("load_b1", 8'h44, 1'b1, 2'd1);
    run_byte("load_b2", 8'h84, 1'b1, 2'd2);
    run_byte("load_b3", 8'hC4, 1'b1, 2'd3);

    run_byte("unload_b0", 8'h06, 1'b0, 2'd0);
    run_byte("unload_b1", 8'h46, 1'b0, 2'd1);
    run_byte("unload_b2", 8'h86, 1'b0, 2'd2);
    run_byte("unload_b3", 8'hC6, 1'b0, 2'd3);

    // COPY: bram_MUX=src, bram_in_MUX=1, b_en=dst
    run_chunk("copy_0to1", 8'h45, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'b0010, 4'd0, 4'd0));
    run_chunk("copy_1to2", 8'h95, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'b0100, 4'd0, 4'd0));
    run_chunk("copy_2to3", 8'hE5, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b1, 4'b1000, 4'd0, 4'd0));
    run_chunk("copy_3to0", 8'h35, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 1'b1, 4'b0001, 4'd0, 4'd0));

    run_chunk("clear_b0", 8'h07, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 4'b0001));
    run_chunk("clear_b1", 8'h47, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 4'b0010));
    run_chunk("clear_b2", 8'h87, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 4'b0100));
    run_chunk("clear_b3", 8'hC7, mk(1'b1, 9'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 4'b1000));

    // ALU: aa=src, dd=dst, out=op, b_en=dst
    run_chunk("add_1to0",  8'h1C, mk(1'b1, 9'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'b0001, 4'd0, 4'd0));
    run_chunk("add_2to1",  8'h6C, mk(1'b1, 9'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 4'b0010, 4'd0, 4'd0));
    run_chunk("add_3to2",  8'hBC, mk(1'b1, 9'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 4'b0100, 4'd0, 4'd0));
    run_chunk("add_0to3",  8'hCC, mk(1'b1, 9'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 4'b1000, 4'd0, 4'd0));
    run_chunk("mul_1to3",  8'hDF, mk(1'b1, 9'd0, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 1'b0, 4'b1000, 4'd0, 4'd0));
    run_chunk("sub_2to2",  8'hAE, mk(1'b1, 9'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 4'b0100, 4'd0, 4'd0));
    run_chunk("shf_3to1",  8'h7D, mk(1'b1, 9'd0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd0, 1'b0, 4'b0010, 4'd0, 4'd0));

    // Reset in the middle of a LOAD to B1 aborts it at once.
    host_instruction = 8'h44;
    tick();
    host_instruction = 8'h00;
    for (int i = 0; i <= 20; i++) begin
      chk("load_abort", i, mk(1'b1, 9'(i * 8), 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0,
                              4'd0, 4'b0010, 4'd0));
      if (i < 20) tick();
    end
    reset = 1'b0;
    tick();
    chk("abort_reset", 0, '0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_nop", i, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
